// File: rtl/instr_mem_responder.sv
// Memory-side responder for the instruction fetch port: zero-wait combinational grant,
// word-addressed instruction array, fixed-latency in-order response pipeline.
module instr_mem_responder #(
  parameter int unsigned ADDR_WIDTH      = 14,
  parameter int unsigned RVALID_LATENCY  = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  stall_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  output logic [2:0]            outstanding_o,
  output logic [31:0]           gnt_count_o,
  output logic                  busy_o
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [2:0]  MAX_OUT = 3'(MAX_OUTSTANDING);

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [31:0]           rd_word;
  logic                  grant;
  logic [2:0]            outstanding;
  logic [31:0]           gnt_count;
  logic                  pipe_vld  [RVALID_LATENCY];
  logic [31:0]           pipe_data [RVALID_LATENCY];
  logic                  unused_addr_bits;

  // Upper address bits alias; the byte offset is irrelevant for word fetches.
  assign rd_idx           = instr_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0]};
  assign rd_word          = mem[rd_idx];

  // A response leaving this cycle frees its slot for a same-cycle grant.
  always_comb begin
    grant = instr_req_i & ~stall_i & ((outstanding < MAX_OUT) | instr_rvalid_o);
  end

  assign instr_gnt_o = grant;

  // Array is not reset; a same-cycle grant reads the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Data only advances with a valid token so the tail holds its last response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RVALID_LATENCY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= grant;
      if (grant) begin
        pipe_data[0] <= rd_word;
      end
      for (int unsigned i = 1; i < RVALID_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign instr_rvalid_o = pipe_vld[RVALID_LATENCY-1];
  assign instr_rdata_o  = pipe_data[RVALID_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (grant && !instr_rvalid_o) begin
      outstanding <= outstanding + 3'd1;
    end else if (!grant && instr_rvalid_o) begin
      outstanding <= outstanding - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_count <= '0;
    end else if (grant) begin
      gnt_count <= gnt_count + 32'd1;
    end
  end

  assign outstanding_o = outstanding;
  assign gnt_count_o   = gnt_count;
  assign busy_o        = (outstanding != '0);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: latency-1 and latency-3 instances with a
// response scoreboard per instance and per-cycle grant/rvalid/outstanding checks.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;

  logic        req_a, stall_a, gnt_a, rvalid_a, busy_a;
  logic [31:0] addr_a, rdata_a, gcnt_a;
  logic [2:0]  out_a;

  logic        req_b, stall_b, gnt_b, rvalid_b, busy_b;
  logic [31:0] addr_b, rdata_b, gcnt_b;
  logic [2:0]  out_b;

  int passed = 0;
  int total  = 0;
  int step_no = 0;

  logic [31:0] model [16384];
  logic [31:0] qa [$];
  logic [31:0] qb [$];

  always #5 clk = ~clk;

  instr_mem_responder #(.ADDR_WIDTH(14), .RVALID_LATENCY(1), .MAX_OUTSTANDING(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(req_a), .instr_addr_i(addr_a), .instr_gnt_o(gnt_a),
    .instr_rvalid_o(rvalid_a), .instr_rdata_o(rdata_a), .stall_i(stall_a),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .outstanding_o(out_a), .gnt_count_o(gcnt_a), .busy_o(busy_a)
  );

  instr_mem_responder #(.ADDR_WIDTH(14), .RVALID_LATENCY(3), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(req_b), .instr_addr_i(addr_b), .instr_gnt_o(gnt_b),
    .instr_rvalid_o(rvalid_b), .instr_rdata_o(rdata_b), .stall_i(stall_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .outstanding_o(out_b), .gnt_count_o(gcnt_b), .busy_o(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s (step %0d): observed %h expected %h", tag, step_no, obs, exp);
  endtask

  // Response scoreboards: every rvalid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rvalid_a === 1'b1) begin
      if (qa.size() == 0) chk("rvalid_a_unexpected", 32'(rvalid_a), 32'd0);
      else chk("rdata_a", rdata_a, qa.pop_front());
    end
    if (rvalid_b === 1'b1) begin
      if (qb.size() == 0) chk("rvalid_b_unexpected", 32'(rvalid_b), 32'd0);
      else chk("rdata_b", rdata_b, qb.pop_front());
    end
  end

  // One cycle: check registered state from the previous edge, drive, then check grant.
  task automatic step(input bit b, input logic req, input logic [31:0] addr, input logic stall,
                      input logic we, input logic [13:0] wa, input logic [31:0] wd,
                      input logic exp_gnt, input logic exp_rv, input logic [2:0] exp_out);
    @(negedge clk);
    step_no = step_no + 1;
    if (b) begin
      chk("rvalid_b", 32'(rvalid_b), 32'(exp_rv));
      chk("outstanding_b", 32'(out_b), 32'(exp_out));
      chk("busy_b", 32'(busy_b), 32'(exp_out != 3'd0));
    end else begin
      chk("rvalid_a", 32'(rvalid_a), 32'(exp_rv));
      chk("outstanding_a", 32'(out_a), 32'(exp_out));
      chk("busy_a", 32'(busy_a), 32'(exp_out != 3'd0));
    end
    req_a   = b ? 1'b0 : req;
    addr_a  = b ? 32'd0 : addr;
    stall_a = b ? 1'b0 : stall;
    req_b   = b ? req : 1'b0;
    addr_b  = b ? addr : 32'd0;
    stall_b = b ? stall : 1'b0;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    #1;
    if (b) chk("gnt_b", 32'(gnt_b), 32'(exp_gnt));
    else   chk("gnt_a", 32'(gnt_a), 32'(exp_gnt));
    if (exp_gnt) begin
      if (b) qb.push_back(model[addr[15:2]]);
      else   qa.push_back(model[addr[15:2]]);
    end
    if (we) model[wa] = wd;
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; addr_a = '0; stall_a = 1'b0;
    req_b = 1'b0; addr_b = '0; stall_b = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    chk("reset_rvalid", 32'(rvalid_a), 32'd0);
    chk("reset_rdata", rdata_a, 32'd0);
    chk("reset_outstanding", 32'(out_a), 32'd0);
    chk("reset_gnt_count", gcnt_a, 32'd0);
    chk("reset_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload words 0..5 and 16 (shared write port feeds both instances)
    step(0, 0, 0, 0, 1, 14'd0,  32'h11,   0, 0, 0);
    step(0, 0, 0, 0, 1, 14'd1,  32'h22,   0, 0, 0);
    step(0, 0, 0, 0, 1, 14'd2,  32'h33,   0, 0, 0);
    step(0, 0, 0, 0, 1, 14'd3,  32'h44,   0, 0, 0);
    step(0, 0, 0, 0, 1, 14'd4,  32'h0400, 0, 0, 0);
    step(0, 0, 0, 0, 1, 14'd5,  32'h55,   0, 0, 0);
    step(0, 0, 0, 0, 1, 14'd16, 32'h1600, 0, 0, 0);

    // Latency 1: back-to-back grants on 0x0,0x4,0x8,0xC
    step(0, 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h4, 0, 0, 0, 0, 1, 1, 1);
    step(0, 1, 32'h8, 0, 0, 0, 0, 1, 1, 1);
    step(0, 1, 32'hC, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("gnt_count_a_after_burst", gcnt_a, 32'd4);
    chk("rdata_a_held", rdata_a, 32'h44);

    // Stall right after a grant: in-flight response still drains, address moves 0x10->0x40
    step(0, 1, 32'h0,  0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h10, 1, 0, 0, 0, 0, 1, 1);
    step(0, 1, 32'h40, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h40, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h40, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 32'h0,  0, 0, 0, 0, 0, 1, 1);

    // Backdoor write colliding with a grant to the same word, then the new value
    step(0, 1, 32'h14, 0, 1, 14'd5, 32'hDEAD, 1, 0, 0);
    step(0, 1, 32'h14, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 32'h0,  0, 0, 0, 0, 0, 1, 1);

    // Upper address bits alias: 0x0001_0004 -> word 1
    step(0, 1, 32'h0001_0004, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("gnt_count_a_total", gcnt_a, 32'd9);

    // Latency 3, two outstanding: grant, grant, wait, grant with first rvalid
    step(1, 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 32'h4, 0, 0, 0, 0, 1, 0, 1);
    step(1, 1, 32'h8, 0, 0, 0, 0, 0, 0, 2);
    step(1, 1, 32'h8, 0, 0, 0, 0, 1, 1, 2);
    step(1, 1, 32'hC, 0, 0, 0, 0, 1, 1, 2);
    step(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 2);
    step(1, 0, 32'h0, 0, 0, 0, 0, 0, 1, 2);
    step(1, 0, 32'h0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("gnt_count_b", gcnt_b, 32'd4);

    // Reset with two responses in flight: both discarded
    step(1, 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 32'h4, 0, 0, 0, 0, 1, 0, 1);
    @(negedge clk);
    req_b = 1'b0;
    rst_n = 1'b0;
    qb.delete();
    #1;
    chk("reset_mid_outstanding", 32'(out_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    end
    chk("reset_mid_gnt_count", gcnt_b, 32'd0);
    chk("reset_mid_rdata", rdata_b, 32'd0);

    chk("queue_a_drained", 32'(qa.size()), 32'd0);
    chk("queue_b_drained", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
